// File: rtl/agu_pkg.sv
// rtl/agu_pkg.sv - shared constants and helpers for the address generation unit
package agu_pkg;

  localparam logic [1:0] SCALE_1 = 2'd0;
  localparam logic [1:0] SCALE_2 = 2'd1;
  localparam logic [1:0] SCALE_4 = 2'd2;
  localparam logic [1:0] SCALE_8 = 2'd3;

  localparam int CH_SRC1 = 0;
  localparam int CH_SRC2 = 1;
  localparam int CH_DEST = 2;

  // Canonical when bits 63..47 are all zeros or all ones.
  function automatic logic canonical_check(input logic [63:0] addr);
    return (addr[63:47] == '0) || (addr[63:47] == '1);
  endfunction

endpackage

// File: rtl/agu_channel.sv
// rtl/agu_channel.sv - per-channel combinational address arithmetic
module agu_channel
  import agu_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DISP_W = 32
) (
  input  logic [ADDR_W-1:0] base_i,
  input  logic              base_valid_i,
  input  logic [ADDR_W-1:0] index_i,
  input  logic              index_valid_i,
  input  logic [1:0]        scale_i,
  input  logic [DISP_W-1:0] disp_i,
  input  logic              rip_rel_i,
  input  logic [ADDR_W-1:0] rip_i,
  output logic [ADDR_W-1:0] partial_o,
  output logic [ADDR_W-1:0] eff_base_o,
  input  logic [ADDR_W-1:0] partial_q_i,
  input  logic [ADDR_W-1:0] eff_base_q_i,
  input  logic              enable_i,
  input  logic              addr32_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              fault_o
);

  logic [ADDR_W-1:0] scaled;
  logic [ADDR_W-1:0] disp_ext;
  logic [ADDR_W-1:0] sum;
  logic              canon;

  always_comb begin
    scaled = '0;
    if (index_valid_i) begin
      case (scale_i)
        SCALE_1: scaled = index_i;
        SCALE_2: scaled = index_i << 1;
        SCALE_4: scaled = index_i << 2;
        SCALE_8: scaled = index_i << 3;
        default: scaled = index_i;
      endcase
    end
  end

  assign disp_ext   = ADDR_W'($signed(disp_i));
  assign partial_o  = scaled + disp_ext;
  assign eff_base_o = rip_rel_i ? rip_i : (base_valid_i ? base_i : '0);

  assign sum = partial_q_i + eff_base_q_i;

  // Only a 64-bit address space has a canonical-form rule to violate.
  if (ADDR_W == 64) begin : g_canon
    assign canon = canonical_check(sum);
  end else begin : g_no_canon
    assign canon = 1'b1;
  end

  always_comb begin
    addr_o  = '0;
    fault_o = 1'b0;
    if (enable_i) begin
      if (addr32_i) begin
        addr_o = ADDR_W'(sum[31:0]);
      end else begin
        addr_o  = sum;
        fault_o = !canon;
      end
    end
  end

endmodule

// File: rtl/address_generation_unit.sv
// rtl/address_generation_unit.sv - two-stage pipelined effective address generator
module address_generation_unit
  import agu_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int NUM_CH = 3,
  parameter int DISP_W = 32,
  parameter int TAG_W  = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flushIn,
  input  logic                     inValidIn,
  output logic                     inReadyOut,
  input  logic [TAG_W-1:0]         tagIn,
  input  logic [ADDR_W-1:0]        currentRipIn,
  input  logic                     addrSize32In,
  input  logic [NUM_CH-1:0]        chEnableIn,
  input  logic [NUM_CH*ADDR_W-1:0] baseIn,
  input  logic [NUM_CH-1:0]        baseValidIn,
  input  logic [NUM_CH*ADDR_W-1:0] indexIn,
  input  logic [NUM_CH-1:0]        indexValidIn,
  input  logic [NUM_CH*2-1:0]      scaleIn,
  input  logic [NUM_CH*DISP_W-1:0] dispIn,
  input  logic [NUM_CH-1:0]        ripRelIn,
  output logic                     outValidOut,
  input  logic                     outReadyIn,
  output logic [TAG_W-1:0]         tagOut,
  output logic [NUM_CH*ADDR_W-1:0] memAddrOut,
  output logic [NUM_CH-1:0]        memAddrValidOut,
  output logic [NUM_CH-1:0]        faultOut
);

  logic              s1_valid_q, s1_valid_d;
  logic [TAG_W-1:0]  s1_tag_q, s1_tag_d;
  logic [NUM_CH-1:0] s1_en_q, s1_en_d;
  logic              s1_a32_q, s1_a32_d;
  logic [ADDR_W-1:0] s1_partial_q [NUM_CH];
  logic [ADDR_W-1:0] s1_partial_d [NUM_CH];
  logic [ADDR_W-1:0] s1_base_q [NUM_CH];
  logic [ADDR_W-1:0] s1_base_d [NUM_CH];

  logic              s2_valid_q, s2_valid_d;
  logic [TAG_W-1:0]  s2_tag_q, s2_tag_d;
  logic [NUM_CH-1:0] s2_en_q, s2_en_d;
  logic [NUM_CH-1:0] s2_fault_q, s2_fault_d;
  logic [ADDR_W-1:0] s2_addr_q [NUM_CH];
  logic [ADDR_W-1:0] s2_addr_d [NUM_CH];

  logic [ADDR_W-1:0] ch_partial [NUM_CH];
  logic [ADDR_W-1:0] ch_base [NUM_CH];
  logic [ADDR_W-1:0] ch_addr [NUM_CH];
  logic [NUM_CH-1:0] ch_fault;

  logic s1_load, s2_load;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    agu_channel #(
      .ADDR_W(ADDR_W),
      .DISP_W(DISP_W)
    ) u_channel (
      .base_i       (baseIn[c*ADDR_W +: ADDR_W]),
      .base_valid_i (baseValidIn[c]),
      .index_i      (indexIn[c*ADDR_W +: ADDR_W]),
      .index_valid_i(indexValidIn[c]),
      .scale_i      (scaleIn[c*2 +: 2]),
      .disp_i       (dispIn[c*DISP_W +: DISP_W]),
      .rip_rel_i    (ripRelIn[c]),
      .rip_i        (currentRipIn),
      .partial_o    (ch_partial[c]),
      .eff_base_o   (ch_base[c]),
      .partial_q_i  (s1_partial_q[c]),
      .eff_base_q_i (s1_base_q[c]),
      .enable_i     (s1_en_q[c]),
      .addr32_i     (s1_a32_q),
      .addr_o       (ch_addr[c]),
      .fault_o      (ch_fault[c])
    );
    assign memAddrOut[c*ADDR_W +: ADDR_W] = s2_addr_q[c];
  end

  assign s2_load    = !s2_valid_q || outReadyIn;
  assign s1_load    = !s1_valid_q || s2_load;
  assign inReadyOut = s1_load;

  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_tag_d     = s1_tag_q;
    s1_en_d      = s1_en_q;
    s1_a32_d     = s1_a32_q;
    s1_partial_d = s1_partial_q;
    s1_base_d    = s1_base_q;
    s2_valid_d   = s2_valid_q;
    s2_tag_d     = s2_tag_q;
    s2_en_d      = s2_en_q;
    s2_fault_d   = s2_fault_q;
    s2_addr_d    = s2_addr_q;

    if (s1_load) begin
      s1_valid_d = inValidIn;
      if (inValidIn) begin
        s1_tag_d     = tagIn;
        s1_en_d      = chEnableIn;
        s1_a32_d     = addrSize32In;
        s1_partial_d = ch_partial;
        s1_base_d    = ch_base;
      end
    end

    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_tag_d   = s1_tag_q;
        s2_en_d    = s1_en_q;
        s2_fault_d = ch_fault;
        s2_addr_d  = ch_addr;
      end
    end

    // Flush wins over both loads; captured data is harmless once valid drops.
    if (flushIn) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      s1_tag_q   <= '0;
      s1_en_q    <= '0;
      s1_a32_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_tag_q   <= '0;
      s2_en_q    <= '0;
      s2_fault_q <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        s1_partial_q[c] <= '0;
        s1_base_q[c]    <= '0;
        s2_addr_q[c]    <= '0;
      end
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_tag_q     <= s1_tag_d;
      s1_en_q      <= s1_en_d;
      s1_a32_q     <= s1_a32_d;
      s1_partial_q <= s1_partial_d;
      s1_base_q    <= s1_base_d;
      s2_valid_q   <= s2_valid_d;
      s2_tag_q     <= s2_tag_d;
      s2_en_q      <= s2_en_d;
      s2_fault_q   <= s2_fault_d;
      s2_addr_q    <= s2_addr_d;
    end
  end

  assign outValidOut     = s2_valid_q;
  assign tagOut          = s2_tag_q;
  assign memAddrValidOut = s2_en_q;
  assign faultOut        = s2_fault_q;

endmodule
